neuron_mac_feeder: RTL and testbench

Producer side of the neuron output stage. It accepts a stream of (input, weight) pairs over a valid/ready handshake and multiply-accumulates them into a signed sum. It drives the term `counter` and the `mult_sum` value that the activation/bias stage consumes. Once COUNTER_END terms are accumulated, it holds the sum and counter stable and asserts `sum_valid` until acknowledged or restarted.

---
 rtl/nn_pkg.sv | 48 ++++
 rtl/neuron_mac_feeder_sat_mac.sv | 31 +++
 rtl/neuron_mac_feeder.sv | 121 ++++++++++++
 tb/tb_neuron_mac_feeder.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared types and saturating arithmetic for the neuron output stage.
package nn_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_e;

  localparam int CNT_W     = 32;
  localparam int ACC_W_DEF = 33;

  localparam logic signed [63:0] ACC_MAX_DEF =
    (64'sd1 <<< (ACC_W_DEF - 1)) - 64'sd1;
  localparam logic signed [63:0] ACC_MIN_DEF =
    -ACC_MAX_DEF - 64'sd1;

  typedef struct packed {
    logic signed [63:0] sum;
    logic               ovf;
  } sat_res_t;

  // Operands are pre-extended to 64 bits so a+b cannot wrap for w < 63.
  function automatic sat_res_t sat_add(
    input logic signed [63:0] a,
    input logic signed [63:0] b,
    input int unsigned        w
  );
    logic signed [63:0] full;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sat_res_t           r;
    hi    = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo    = -hi - 64'sd1;
    full  = a + b;
    r.ovf = 1'b1;
    if (full > hi) begin
      r.sum = hi;
    end else if (full < lo) begin
      r.sum = lo;
    end else begin
      r.sum = full;
      r.ovf = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/neuron_mac_feeder_sat_mac.sv
// Combinational multiply-accumulate with clamping at the accumulator
// limits; ovf flags that the result was clamped.
module sat_mac
  import nn_pkg::*;
#(
  parameter int BITS   = 8,
  parameter int W_BITS = 16,
  parameter int ACC_W  = BITS + 25
) (
  input  logic signed [BITS-1:0]   x_in,
  input  logic signed [W_BITS-1:0] w_in,
  input  logic signed [ACC_W-1:0]  acc_in,
  output logic signed [ACC_W-1:0]  sum_out,
  output logic                     ovf
);

  localparam int PW = BITS + W_BITS;

  logic signed [PW-1:0] x_ext;
  logic signed [PW-1:0] w_ext;
  logic signed [PW-1:0] prod;
  sat_res_t             res;

  assign x_ext   = PW'(x_in);
  assign w_ext   = PW'(w_in);
  assign prod    = x_ext * w_ext;
  assign res     = sat_add(64'(acc_in), 64'(prod), ACC_W);
  assign sum_out = ACC_W'(res.sum);
  assign ovf     = res.ovf;

endmodule

// File: rtl/neuron_mac_feeder.sv
// Producer side of the neuron output stage: accumulates COUNTER_END
// (x, w) products and presents the saturated sum until acknowledged.
module neuron_mac_feeder
  import nn_pkg::*;
#(
  parameter int BITS        = 8,
  parameter int W_BITS      = 16,
  parameter int COUNTER_END = 4,
  parameter int ACC_W       = BITS + 25
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic signed [BITS-1:0]  x_in,
  input  logic signed [W_BITS-1:0] w_in,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    out_ack,
  output logic [CNT_W-1:0]        counter,
  output logic signed [ACC_W-1:0] mult_sum,
  output logic                    sum_valid,
  output logic                    sat_flag
);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        counter_q, counter_d;
  logic signed [ACC_W-1:0] sum_q, sum_d;
  logic                    sat_q, sat_d;
  logic                    in_ready_q, in_ready_d;
  logic                    sum_valid_q, sum_valid_d;

  logic signed [ACC_W-1:0] mac_sum;
  logic                    mac_ovf;
  logic                    accept;
  logic [CNT_W-1:0]        cnt_inc;

  sat_mac #(
    .BITS   (BITS),
    .W_BITS (W_BITS),
    .ACC_W  (ACC_W)
  ) u_sat_mac (
    .x_in    (x_in),
    .w_in    (w_in),
    .acc_in  (sum_q),
    .sum_out (mac_sum),
    .ovf     (mac_ovf)
  );

  assign accept  = in_valid && in_ready_q;
  assign cnt_inc = counter_q + 32'd1;

  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    sum_d     = sum_q;
    sat_d     = sat_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = ACCUM;
          counter_d = '0;
          sum_d     = '0;
          sat_d     = 1'b0;
        end
      end
      ACCUM: begin
        // A restart drops whatever beat is offered alongside it.
        if (start) begin
          counter_d = '0;
          sum_d     = '0;
          sat_d     = 1'b0;
        end else if (accept) begin
          counter_d = cnt_inc;
          sum_d     = mac_sum;
          sat_d     = sat_q | mac_ovf;
          if (cnt_inc == 32'(COUNTER_END)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (start) begin
          state_d   = ACCUM;
          counter_d = '0;
          sum_d     = '0;
          sat_d     = 1'b0;
        end else if (out_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == ACCUM);
    sum_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      counter_q   <= '0;
      sum_q       <= '0;
      sat_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      sum_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      counter_q   <= counter_d;
      sum_q       <= sum_d;
      sat_q       <= sat_d;
      in_ready_q  <= in_ready_d;
      sum_valid_q <= sum_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign sum_valid = sum_valid_q;
  assign counter   = counter_q;
  assign mult_sum  = sum_q;
  assign sat_flag  = sat_q;

endmodule

// File: tb/tb_neuron_mac_feeder.sv
// Randomized scoreboard bench for neuron_mac_feeder against a
// sum-of-products reference with clamping.
module tb_neuron_mac_feeder;

  localparam int BITS   = 8;
  localparam int W_BITS = 16;
  localparam int CE     = 4;
  localparam int ACC_W  = 24;

  localparam longint AMAX = (longint'(1) <<< (ACC_W - 1)) - 1;
  localparam longint AMIN = -AMAX - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [BITS-1:0]   x_in = '0;
  logic [W_BITS-1:0] w_in = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              out_ack = 1'b0;
  logic [31:0]       counter;
  logic [ACC_W-1:0]  mult_sum;
  logic              sum_valid;
  logic              sat_flag;

  neuron_mac_feeder #(
    .BITS        (BITS),
    .W_BITS      (W_BITS),
    .COUNTER_END (CE),
    .ACC_W       (ACC_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .x_in      (x_in),
    .w_in      (w_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_ack   (out_ack),
    .counter   (counter),
    .mult_sum  (mult_sum),
    .sum_valid (sum_valid),
    .sat_flag  (sat_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint sum;
    bit     sat;
  } exp_t;

  exp_t   sbq[$];
  int     n_chk = 0;
  int     n_fail = 0;
  int     phase = 0;
  longint m_sum = 0;
  bit     m_sat = 0;
  int     m_cnt = 0;
  bit     sv_prev = 0;

  function automatic longint clamp(longint v);
    if (v > AMAX) return AMAX;
    if (v < AMIN) return AMIN;
    return v;
  endfunction

  function automatic longint sum_s();
    return longint'($signed(mult_sum));
  endfunction

  function automatic int rx();
    case ($urandom_range(0, 3))
      0: return 127;
      1: return -128;
      default: return int'($urandom_range(0, 255)) - 128;
    endcase
  endfunction

  function automatic int rw();
    case ($urandom_range(0, 3))
      0: return 32767;
      1: return -32768;
      default: return int'($urandom_range(0, 65535)) - 32768;
    endcase
  endfunction

  task automatic chk(string nm, logic signed [63:0] act,
                     logic signed [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the reference advances for the coming edge.
  task automatic cycle(bit st, bit ack, bit v, int x, int w);
    longint t;
    @(negedge clk);
    chk("in_ready", {63'd0, in_ready}, {63'd0, phase == 1});
    chk("sum_valid", {63'd0, sum_valid}, {63'd0, phase == 2});
    chk("counter", {32'd0, counter}, 64'(m_cnt));
    chk("mult_sum", sum_s(), m_sum);
    chk("sat_flag", {63'd0, sat_flag}, {63'd0, m_sat});
    start    = st;
    out_ack  = ack;
    in_valid = v;
    x_in     = BITS'(x);
    w_in     = W_BITS'(w);
    if (st) begin
      phase = 1;
      m_sum = 0;
      m_sat = 0;
      m_cnt = 0;
    end else if (phase == 1 && v) begin
      t = m_sum + longint'(x) * longint'(w);
      if (t > AMAX || t < AMIN) m_sat = 1;
      m_sum = clamp(t);
      m_cnt++;
      if (m_cnt == CE) begin
        phase = 2;
        sbq.push_back('{m_sum, m_sat});
      end
    end else if (phase == 2 && ack) begin
      phase = 0;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sv_prev = 0;
    end else begin
      if (sum_valid && !sv_prev) begin
        if (sbq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL sb_empty: sum_valid with no expected sum");
        end else begin
          e = sbq.pop_front();
          chk("sb_sum", sum_s(), e.sum);
          chk("sb_sat", {63'd0, sat_flag}, {63'd0, e.sat});
          chk("sb_cnt", {32'd0, counter}, 64'(CE));
        end
      end
      sv_prev = sum_valid;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #1;
    chk("rst_counter", {32'd0, counter}, 64'd0);
    chk("rst_sum", sum_s(), 64'd0);
    chk("rst_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_valid", {63'd0, sum_valid}, 64'd0);
    chk("rst_sat", {63'd0, sat_flag}, 64'd0);
    #10 rst_n = 1'b1;

    // basic sum, back-to-back
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 1, 2, 5);
    cycle(0, 0, 1, -3, 6);
    cycle(0, 0, 1, 4, -1);
    cycle(0, 0, 1, 0, 7);
    cycle(0, 1, 0, 0, 0);
    chk("basic_sum", sum_s(), -64'sd12);
    chk("basic_done_ready", {63'd0, in_ready}, 64'd0);
    cycle(0, 0, 0, 0, 0);

    // backpressure gaps
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 1, 2, 5);
    cycle(0, 0, 0, 9, 9);
    cycle(0, 0, 0, 9, 9);
    cycle(0, 0, 1, -3, 6);
    cycle(0, 0, 0, 9, 9);
    cycle(0, 0, 1, 4, -1);
    cycle(0, 0, 0, 9, 9);
    cycle(0, 0, 1, 0, 7);
    cycle(0, 1, 0, 0, 0);
    chk("gap_sum", sum_s(), -64'sd12);

    // positive and negative saturation
    cycle(1, 0, 0, 0, 0);
    repeat (4) cycle(0, 0, 1, 127, 32767);
    cycle(0, 1, 0, 0, 0);
    chk("sat_pos_sum", sum_s(), 64'sd8388607);
    chk("sat_pos_flag", {63'd0, sat_flag}, 64'd1);
    cycle(1, 0, 0, 0, 0);
    repeat (4) cycle(0, 0, 1, -128, 32767);
    cycle(0, 1, 0, 0, 0);
    chk("sat_neg_sum", sum_s(), -64'sd8388608);

    // restart with a coincident beat
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 1, 50, 50);
    cycle(0, 0, 1, 60, 60);
    cycle(1, 0, 1, 70, 70);
    repeat (4) cycle(0, 0, 1, 1, 1);
    cycle(0, 0, 1, 5, 5);
    chk("restart_sum", sum_s(), 64'sd4);

    // hold DONE, then start and ack together
    repeat (5) cycle(0, 0, 1, 3, 3);
    cycle(1, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    chk("startack_cnt", {32'd0, counter}, 64'd0);

    // asynchronous reset mid-accumulation
    cycle(0, 0, 1, 10, 10);
    cycle(0, 0, 1, 11, 11);
    cycle(0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_counter", {32'd0, counter}, 64'd0);
    chk("arst_sum", sum_s(), 64'd0);
    chk("arst_ready", {63'd0, in_ready}, 64'd0);
    chk("arst_valid", {63'd0, sum_valid}, 64'd0);
    phase = 0;
    m_sum = 0;
    m_sat = 0;
    m_cnt = 0;
    #1 rst_n = 1'b1;
    repeat (4) cycle(0, 0, 1, 7, 7);

    // randomized neurons with gaps, restarts and mixed exits
    for (int n = 0; n < 60; n++) begin
      cycle(1, 0, 0, 0, 0);
      for (int k = 0; k < 100 && phase == 1; k++) begin
        bit v;
        bit rs;
        v  = ($urandom_range(0, 3) != 0);
        rs = ($urandom_range(0, 39) == 0);
        cycle(rs, 0, v, rx(), rw());
      end
      repeat ($urandom_range(0, 3)) cycle(0, 0, 1, rx(), rw());
      case ($urandom_range(0, 2))
        0: cycle(0, 1, 0, 0, 0);
        1: cycle(1, 1, 0, 0, 0);
        default: cycle(1, 0, 1, rx(), rw());
      endcase
    end
    repeat (3) cycle(0, 1, 0, 0, 0);
    chk("sb_drained", 64'(sbq.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
